// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between IF and MEM.
// Ports: clk/reset, IF (i_*), MEM (d_*), memory (mem_*), stall_if/stall_mem/busy.
// Optional MEM_ARB_FAIR_EN: round-robin tie-break instead of data priority.
module mem_port_arbiter #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LD = 4'(MEM_LATENCY - 1);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nx;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_we;

  logic i_eff;
  logic d_eff;
  logic pick_d;
  logic gnt_i;
  logic gnt_d;
  logic done;

  // A requester is not eligible in its own ready cycle.
  assign i_eff = i_req & ~i_ready;
  assign d_eff = d_req & ~d_ready;

`ifdef MEM_ARB_FAIR_EN
  // 0 = I granted last, 1 = D granted last.
  logic last_grant;

  assign pick_d = ~last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (gnt_d) begin
      last_grant <= 1'b1;
    end else if (gnt_i) begin
      last_grant <= 1'b0;
    end
  end
`else
  assign pick_d = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        // pick_d only matters on a tie.
        gnt_d = d_eff & (~i_eff | pick_d);
        gnt_i = i_eff & ~gnt_d;
        if (gnt_d) begin
          state_nx = D_ACC;
          cnt_nx   = CNT_LD;
        end else if (gnt_i) begin
          state_nx = I_ACC;
          cnt_nx   = CNT_LD;
        end
      end
      I_ACC, D_ACC: begin
        if (cnt == 4'd0) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_we    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (gnt_d) begin
        acc_addr  <= d_addr;
        acc_wdata <= d_wdata;
        acc_we    <= d_we;
      end
      if (gnt_i) begin
        acc_addr <= i_addr;
        acc_we   <= 1'b0;
      end
      if (done && state == I_ACC) begin
        i_rdata <= mem_rdata;
        i_ready <= 1'b1;
      end
      if (done && state == D_ACC) begin
        d_ready <= 1'b1;
        // Stores leave the load data register untouched.
        if (!acc_we) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_req   = busy;
  assign mem_we    = busy & acc_we;
  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;

  assign stall_if  = i_req & ~i_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule
